ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
- Receiver/decoder for the single-wire WS2812 LED protocol: the other end of the existing ws2812 transmitter.
- Samples a WS2812 data line (pmod input), classifies each high pulse as 0/1 by width and assembles 24-bit pixel words.
- Reports each word with its position in the frame and detects the low reset gap as end of frame.
- Used for transmitter loopback self-test on the PMOD, and for acting as a WS2812 "pixel" fed by an external controller.

Parameters:
- BIT_THRESH, 8: high-pulse length in clk cycles at or above which a bit decodes as 1 (8 cycles = 667 ns at 12 MHz).
- HIGH_MAX, 24: high-pulse length in cycles above which the pulse is illegal (error).
- RESET_CYCLES, 600: consecutive low cycles that constitute a frame reset gap (50 us at 12 MHz).
- NUM_LEDS, 40: words accepted per frame; legal led_num values are 0..NUM_LEDS-1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- din, input, 1: WS2812 serial line, asynchronous to clk.
- rgb_data, output, 24: last decoded word; the first bit received on the wire is at bit 23 (same bit order as the transmitter's rgb_data input).
- led_num, output, 8: frame position of rgb_data.
- valid, output, 1: one-cycle pulse; rgb_data and led_num are updated in the same cycle.
- frame_done, output, 1: one-cycle pulse when a reset gap ends a frame.
- err, output, 1: one-cycle pulse on any protocol error.
- dout, output, 1: forwarded stream (see Optional Feature); constant 0 when that feature is compiled out.

Behaviour:
- din passes through a 2-flop synchroniser; all logic uses the synchronised value ds. Add 2 cycles of input latency.
- Reset values: rgb_data=0, led_num=0, valid=0, frame_done=0, err=0, dout=0, state=SYNC, all counters=0.
- hi_cnt counts consecutive cycles with ds=1. lo_cnt counts consecutive cycles with ds=0. Both saturate and both clear on the opposite level.
- State SYNC:
  - Ignore all pulses and produce no valid.
  - When lo_cnt reaches RESET_CYCLES, go to RECV with bit_cnt=0 and word index=0.
  - No frame_done is produced on leaving SYNC.
  - Purpose: a receiver that comes up mid-frame never emits misaligned words.
- State RECV, on the ds falling edge (ds=0, previous ds=1):
  - Decoded bit = (hi_cnt >= BIT_THRESH), shifted in MSB first; bit_cnt increments.
  - When bit_cnt reaches 24:
    - If word index < NUM_LEDS: rgb_data <= the assembled word, led_num <= index, valid=1 on the next cycle, index increments.
    - Otherwise: drop the word, pulse err once, and keep dropping words until the reset gap.
    - bit_cnt returns to 0.
- RECV, hi_cnt exceeds HIGH_MAX: pulse err, go to SYNC. A stuck-high line is caught here.
- RECV, lo_cnt reaches RESET_CYCLES:
  - Pulse frame_done exactly once; a longer gap does not repeat it.
  - Index resets to 0.
  - If bit_cnt != 0, discard the partial word and pulse err in the same cycle as frame_done.
  - Stay in RECV.
- Frame with zero words (an extra reset gap): frame_done is still pulsed, provided the gap follows at least one high pulse since the previous frame_done.
- Falling edge and reset-gap completion cannot coincide, since the gap requires ds low for RESET_CYCLES.
- valid, frame_done and err are registered. valid follows the completing falling edge by exactly 1 cycle (3 cycles from din, including the synchroniser).
- A reset asserted mid-frame returns the block to SYNC. The remainder of the interrupted frame is ignored.

Optional Feature:
- Macro: WS2812_RX_FORWARD_EN.
- Defined:
  - dout reproduces ds, delayed by one register, for all bits after the first 24 of each frame. The block behaves like a real pixel: it consumes word 0 and forwards the rest down the chain.
  - dout=0 during word 0, in SYNC, and during the reset gap.
  - Words 1.. are still decoded and reported on valid.
- Not defined: dout is tied to 0 and no forwarding logic is built.

Test Plan:
- Reset, then an 800-cycle low gap, then one word 0x100000 (1 = 10 cycles high / 5 low, 0 = 4 high / 11 low), then a 700-cycle low gap -> single valid with rgb_data=0x100000, led_num=0; then frame_done=1 once; err never set.
- 40 words 0x000010, 0x001000, ... then a gap -> 40 valid pulses, led_num 0..39 in order, one frame_done.
- 41 words in one frame -> 40 valids, err pulse on word 41, led_num never exceeds 39; the next frame restarts at led_num=0.
- Stream starts mid-word with no preceding gap (12 stray bits, then gap, then word 0xABCDEF) -> no valid before the gap; exactly one valid, 0xABCDEF at led_num=0.
- 10 bits then a gap -> err and frame_done in the same cycle, no valid. Separately, din held high for 30 cycles -> err, then no valid until after the next 600-cycle gap.
- With WS2812_RX_FORWARD_EN: 3 words -> dout low during word 0, then a 1-cycle-delayed copy of words 1-2 equal to ds; without the macro, dout stays 0 throughout.

Source files
------------

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receiver, pulse-width decode into 24-bit words with frame position.
// Optional WS2812_RX_FORWARD_EN: forward everything after word 0 on dout, like a real pixel.
//   state | meaning
//   SYNC  | alignment unknown; wait for a reset gap before trusting any bit
//   RECV  | decoding bits into words, counting words within the frame
module ws2812_rx #(
    parameter int BIT_THRESH   = 8,
    parameter int HIGH_MAX     = 24,
    parameter int RESET_CYCLES = 600,
    parameter int NUM_LEDS     = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic        err,
    output logic        dout
);
    localparam int HW = $clog2(HIGH_MAX + 2);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    typedef enum logic {SYNC, RECV} state_t;
    state_t state_q, state_d;

    logic          d_meta, ds, ds_prev;
    logic [HW-1:0] hi_cnt;
    logic [LW-1:0] lo_cnt;
    logic [4:0]    bit_cnt;
    logic [23:0]   shift_q, shift_d;
    logic [7:0]    idx_q;
    logic          ovf_q, seen_hi_q;

    logic fall, gap_hit, hi_over, word_done, bit_val;
    logic valid_d, frame_done_d, err_d;
    logic shift_en, bit_clr, idx_clr, word_load, ovf_set, seen_clr;

    assign fall      = ds_prev & ~ds;
    assign gap_hit   = ~ds && (lo_cnt == LW'(RESET_CYCLES - 1));
    assign hi_over   = ds && (hi_cnt == HW'(HIGH_MAX));
    assign word_done = (bit_cnt == 5'd23);
    assign bit_val   = (hi_cnt >= HW'(BIT_THRESH));
    assign shift_d   = {shift_q[22:0], bit_val};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        shift_en     = 1'b0;
        bit_clr      = 1'b0;
        idx_clr      = 1'b0;
        word_load    = 1'b0;
        ovf_set      = 1'b0;
        seen_clr     = 1'b0;
        case (state_q)
            SYNC: begin
                if (gap_hit) begin
                    state_d  = RECV;
                    bit_clr  = 1'b1;
                    idx_clr  = 1'b1;
                    seen_clr = 1'b1;
                end
            end
            RECV: begin
                if (hi_over) begin
                    err_d   = 1'b1;
                    state_d = SYNC;
                end else if (fall) begin
                    shift_en = 1'b1;
                    if (word_done) begin
                        bit_clr = 1'b1;
                        if (idx_q < 8'(NUM_LEDS)) begin
                            word_load = 1'b1;
                            valid_d   = 1'b1;
                        end else if (!ovf_q) begin
                            // only the first surplus word of a frame is flagged
                            err_d   = 1'b1;
                            ovf_set = 1'b1;
                        end
                    end
                end else if (gap_hit) begin
                    bit_clr      = 1'b1;
                    idx_clr      = 1'b1;
                    seen_clr     = 1'b1;
                    frame_done_d = seen_hi_q;
                    err_d        = (bit_cnt != 5'd0);
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_meta     <= 1'b0;
            ds         <= 1'b0;
            ds_prev    <= 1'b0;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            seen_hi_q  <= 1'b0;
            rgb_data   <= '0;
            led_num    <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            d_meta  <= din;
            ds      <= d_meta;
            ds_prev <= ds;

            if (ds) begin
                lo_cnt <= '0;
                if (hi_cnt != HW'(HIGH_MAX + 1)) hi_cnt <= hi_cnt + 1'b1;
            end else begin
                hi_cnt <= '0;
                if (lo_cnt != LW'(RESET_CYCLES)) lo_cnt <= lo_cnt + 1'b1;
            end

            if (bit_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
            if (shift_en)      shift_q <= shift_d;

            if (idx_clr) begin
                idx_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (word_load) idx_q <= idx_q + 1'b1;
                if (ovf_set)   ovf_q <= 1'b1;
            end

            if (word_load) begin
                rgb_data <= shift_d;
                led_num  <= idx_q;
            end

            if (seen_clr)                   seen_hi_q <= 1'b0;
            else if (state_q == RECV && ds) seen_hi_q <= 1'b1;

            valid      <= valid_d;
            frame_done <= frame_done_d;
            err        <= err_d;
        end
    end

`ifdef WS2812_RX_FORWARD_EN
    logic fwd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_q <= 1'b0;
            dout  <= 1'b0;
        end else begin
            dout <= fwd_q & ds;
            if (state_q != RECV || gap_hit || hi_over)
                fwd_q <= 1'b0;
            else if (shift_en && word_done && idx_q == 8'd0)
                fwd_q <= 1'b1;
        end
    end
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized self-checking bench for ws2812_rx against a word/frame-level model.
module tb_ws2812_rx;
    localparam int CLK_P    = 10;
    localparam int NUM_LEDS = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b0;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        valid, frame_done, err, dout;

    ws2812_rx dut (
        .clk(clk), .reset(reset), .din(din), .rgb_data(rgb_data), .led_num(led_num),
        .valid(valid), .frame_done(frame_done), .err(err), .dout(dout)
    );

    always #(CLK_P / 2) clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_q[$];
    int          lat_q[$];
    int          fd_cnt, err_cnt, coin_cnt, dout_bad, dout_ones, max_led;
    time         last_fall_t = 0;
    bit          chk_dout = 1'b0;
    bit          fwd_window = 1'b0;
    logic [2:0]  hist = '0;

    always @(posedge clk) hist <= {hist[1:0], din};

    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                got_q.push_back({led_num, rgb_data});
                lat_q.push_back(int'(($time - last_fall_t) / CLK_P));
                if (int'(led_num) > max_led) max_led = int'(led_num);
            end
            if (frame_done) fd_cnt++;
            if (err) err_cnt++;
            if (err && frame_done) coin_cnt++;
            if (chk_dout) begin
                if (dout !== (fwd_window ? hist[2] : 1'b0)) dout_bad++;
                if (dout) dout_ones++;
            end
        end
    end

    task automatic clear_log();
        @(posedge clk);
        got_q.delete();
        lat_q.delete();
        fd_cnt = 0; err_cnt = 0; coin_cnt = 0; dout_bad = 0; dout_ones = 0; max_led = 0;
        @(negedge clk);
    endtask

    task automatic level(input logic v, input int n);
        if (din && !v) last_fall_t = $time;
        din = v;
        repeat (n) @(negedge clk);
    endtask

    // mode 0: 1 = 10 high / 5 low, 0 = 4 high / 11 low; mode 1: randomized legal widths
    task automatic send_word(input logic [23:0] w, input int mode);
        for (int i = 23; i >= 0; i--) begin
            if (mode == 0) begin
                if (w[i]) begin level(1'b1, 10); level(1'b0, 5);  end
                else      begin level(1'b1, 4);  level(1'b0, 11); end
            end else begin
                level(1'b1, w[i] ? $urandom_range(12, 8) : $urandom_range(5, 1));
                level(1'b0, $urandom_range(6, 3));
            end
        end
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            level(1'b1, $urandom_range(12, 1));
            level(1'b0, $urandom_range(6, 3));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (rgb_data !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", rgb_data); end
        checks++; if (led_num !== 8'h0) begin errors++; $display("FAIL reset_led got %0d want 0", led_num); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout got %b want 0", dout); end
        reset = 1'b0;
`ifndef WS2812_RX_FORWARD_EN
        chk_dout = 1'b1;
`endif
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_word();
        clear_log();
        level(1'b0, 800);
        send_word(24'h100000, 0);
        level(1'b0, 700);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", got_q.size()); end
        if (got_q.size() == 1) begin
            checks++; if (got_q[0] !== {8'd0, 24'h100000}) begin errors++; $display("FAIL single_word got %h want 00100000", got_q[0]); end
            checks++; if (lat_q[0] !== 3) begin errors++; $display("FAIL single_latency got %0d want 3", lat_q[0]); end
        end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL single_fd got %0d want 1", fd_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL single_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_frame(input string name, input int n, input int mode);
        logic [23:0] w;
        logic [31:0] exp_q[$];
        int exp_err;
        clear_log();
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? 24'h000010 : (i == 1) ? 24'h001000 : 24'($urandom);
            if (i < NUM_LEDS) exp_q.push_back({8'(i), w});
            send_word(w, mode);
        end
        exp_err = (n > NUM_LEDS) ? 1 : 0;
        level(1'b0, 700);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL %s_count got %0d want %0d", name, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_word%0d got %h want %h", name, i, got_q[i], exp_q[i]); end
            checks++; if (lat_q[i] !== 3) begin errors++; $display("FAIL %s_lat%0d got %0d want 3", name, i, lat_q[i]); end
        end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL %s_fd got %0d want 1", name, fd_cnt); end
        checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL %s_err got %0d want %0d", name, err_cnt, exp_err); end
        checks++; if (max_led > NUM_LEDS - 1) begin errors++; $display("FAIL %s_maxled got %0d want <=%0d", name, max_led, NUM_LEDS - 1); end
    endtask

    task automatic test_overflow();
        test_frame("overflow", NUM_LEDS + 1, 1);
        test_frame("after_ovf", 2, 1);
    endtask

    task automatic test_boundary();
        int widths[4] = '{7, 8, 24, 1};
        int wd;
        logic [23:0] exp_w[3];
        clear_log();
        for (int k = 0; k < 3; k++) begin
            for (int i = 23; i >= 0; i--) begin
                wd = (k == 0) ? widths[i % 4] : widths[$urandom_range(3, 0)];
                exp_w[k][i] = (wd >= 8);
                level(1'b1, wd);
                level(1'b0, $urandom_range(8, 3));
            end
        end
        level(1'b0, 700);
        level(1'b0, 1500);
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL bound_count got %0d want 3", got_q.size()); end
        for (int k = 0; k < 3 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== {8'(k), exp_w[k]}) begin errors++; $display("FAIL bound_word%0d got %h want %h", k, got_q[k], {8'(k), exp_w[k]}); end
        end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL bound_fd got %0d want 1", fd_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL bound_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_partial();
        clear_log();
        send_bits(10);
        level(1'b0, 700);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL partial_valid got %0d want 0", got_q.size()); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL partial_err got %0d want 1", err_cnt); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL partial_fd got %0d want 1", fd_cnt); end
        checks++; if (coin_cnt !== 1) begin errors++; $display("FAIL partial_coincide got %0d want 1", coin_cnt); end
    endtask

    task automatic test_stuck_high();
        logic [23:0] w2;
        w2 = 24'($urandom);
        clear_log();
        level(1'b1, 30);
        level(1'b0, 100);
        send_word(24'($urandom), 1);
        level(1'b0, 700);
        send_word(w2, 1);
        level(1'b0, 700);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL stuck_err got %0d want 1", err_cnt); end
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL stuck_count got %0d want 1", got_q.size()); end
        if (got_q.size() == 1) begin
            checks++; if (got_q[0] !== {8'd0, w2}) begin errors++; $display("FAIL stuck_word got %h want %h", got_q[0], {8'd0, w2}); end
        end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL stuck_fd got %0d want 1", fd_cnt); end
    endtask

    task automatic test_midstream();
        send_bits(10);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_log();
        checks++; if (rgb_data !== 24'h0) begin errors++; $display("FAIL mid_rst_rgb got %h want 000000", rgb_data); end
        send_bits(12);
        level(1'b0, 700);
        send_word(24'hABCDEF, 1);
        level(1'b0, 700);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL mid_count got %0d want 1", got_q.size()); end
        if (got_q.size() == 1) begin
            checks++; if (got_q[0] !== {8'd0, 24'hABCDEF}) begin errors++; $display("FAIL mid_word got %h want 00abcdef", got_q[0]); end
        end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL mid_err got %0d want 0", err_cnt); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL mid_fd got %0d want 1", fd_cnt); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 2; f++) test_frame("random", $urandom_range(8, 1), 1);
    endtask

    task automatic test_dout();
`ifdef WS2812_RX_FORWARD_EN
        clear_log();
        chk_dout = 1'b1;
        fwd_window = 1'b0;
        send_word(24'($urandom), 1);
        fwd_window = 1'b1;
        send_word(24'hFFFFFF, 1);
        send_word(24'($urandom), 1);
        level(1'b0, 700);
        fwd_window = 1'b0;
        level(1'b0, 20);
        chk_dout = 1'b0;
        checks++; if (dout_bad !== 0) begin errors++; $display("FAIL fwd_dout got %0d bad cycles want 0", dout_bad); end
        checks++; if (dout_ones < 24) begin errors++; $display("FAIL fwd_active got %0d high cycles want >=24", dout_ones); end
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL fwd_valid got %0d want 3", got_q.size()); end
`else
        send_word(24'hFFFFFF, 1);
        send_word(24'hFFFFFF, 1);
        level(1'b0, 700);
        checks++; if (dout_bad !== 0) begin errors++; $display("FAIL dout_idle got %0d nonzero cycles want 0", dout_bad); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_frame("full", NUM_LEDS, 1);
        test_overflow();
        test_boundary();
        test_partial();
        test_stuck_high();
        test_midstream();
        test_random();
        test_dout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
